// File: rtl/spi_ram_pkg.sv
// Shared command and FSM state encodings for the SPI-attached RAM.
// Used by spi_ram and spi_ram_mem.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TX   = 1'b1
    } state_e;

    localparam int CMD_W = 2;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM, no reset.
// A write takes priority over a read, and rdata changes only on a read.
module spi_ram_mem
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int DATA_W    = 8,
    parameter int AW        = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/spi_ram.sv
// Command decoder, address registers and tx hold FSM in front of spi_ram_mem.
// The optional macro SPI_RAM_AUTOINC_EN makes the addresses auto-increment after each data access.
//
// state   | meaning
// IDLE    | tx_valid low, dout keeps last read value
// TX      | tx_valid high for TX_HOLD cycles while dout is serialized
module spi_ram
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int TX_HOLD   = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] din,
    input  logic                 rx_valid,
    output logic [ADDR_SIZE-1:0] dout,
    output logic                 tx_valid,
    output logic                 seq_err
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CW = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;

    cmd_e                 cmd;
    logic [ADDR_SIZE-1:0] payload;
    logic [AW-1:0]        wr_addr;
    logic [AW-1:0]        rd_addr;
    logic                 rd_addr_vld;
    state_e               state;
    logic [CW-1:0]        hold_cnt;
    logic                 rd_seen;
    logic                 wr_cmd;
    logic                 rd_cmd;
    logic [ADDR_SIZE-1:0] mem_rdata;

    assign cmd     = cmd_e'(din[ADDR_SIZE+1 -: CMD_W]);
    assign payload = din[ADDR_SIZE-1:0];
    assign wr_cmd  = rx_valid && (cmd == CMD_WR_DATA);
    assign rd_cmd  = rx_valid && (cmd == CMD_RD_DATA);

    function automatic logic [AW-1:0] wrap_addr(input logic [ADDR_SIZE-1:0] p);
        logic [31:0] v;
        v = 32'(p) % 32'(MEM_DEPTH);
        return v[AW-1:0];
    endfunction

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == AW'(MEM_DEPTH - 1)) ? '0 : a + AW'(1);
    endfunction

    spi_ram_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .DATA_W    (ADDR_SIZE),
        .AW        (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_cmd),
        .re    (rd_cmd),
        .addr  (wr_cmd ? wr_addr : rd_addr),
        .wdata (payload),
        .rdata (mem_rdata)
    );

    // RAM output has no reset, so dout is gated to zero until the first read after reset.
    assign dout = rd_seen ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr     <= '0;
            rd_addr     <= '0;
            rd_addr_vld <= 1'b0;
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            tx_valid    <= 1'b0;
            seq_err     <= 1'b0;
            rd_seen     <= 1'b0;
        end else begin
            seq_err <= 1'b0;
            if (rx_valid) begin
                unique case (cmd)
                    CMD_WR_ADDR: wr_addr <= wrap_addr(payload);
                    CMD_WR_DATA: begin
`ifdef SPI_RAM_AUTOINC_EN
                        wr_addr <= next_addr(wr_addr);
`endif
                    end
                    CMD_RD_ADDR: begin
                        rd_addr     <= wrap_addr(payload);
                        rd_addr_vld <= 1'b1;
                    end
                    CMD_RD_DATA: begin
                        seq_err <= !rd_addr_vld;
`ifdef SPI_RAM_AUTOINC_EN
                        rd_addr <= next_addr(rd_addr);
`else
                        rd_addr_vld <= 1'b0;
`endif
                    end
                endcase
            end

            if (rd_cmd) begin
                state    <= ST_TX;
                hold_cnt <= '0;
                tx_valid <= 1'b1;
                rd_seen  <= 1'b1;
            end else if (state == ST_TX) begin
                if (hold_cnt == CW'(TX_HOLD - 1)) begin
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                    tx_valid <= 1'b0;
                end else begin
                    hold_cnt <= hold_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_ram.sv
// Directed bench for spi_ram: a transaction-level model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_spi_ram;

    localparam int DEPTH = 256;
    localparam int HOLD  = 10;
`ifdef SPI_RAM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] dout;
    logic       tx_valid;
    logic       seq_err;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    spi_ram #(.MEM_DEPTH(DEPTH), .ADDR_SIZE(8), .TX_HOLD(HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .seq_err  (seq_err)
    );

    always #5 clk = ~clk;

    // Transaction-level model
    logic [7:0] m_mem [DEPTH];
    bit         m_known [DEPTH];
    int         m_wr = 0, m_rd = 0, m_left = 0;
    bit         m_vld = 0, m_seq = 0, m_dknown = 1;
    logic [7:0] m_dout = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wr = 0; m_rd = 0; m_vld = 0; m_left = 0; m_seq = 0;
            m_dout = '0; m_dknown = 1;
        end else begin
            m_seq = 0;
            if (m_left > 0) m_left = m_left - 1;
            if (rx_valid) begin
                case (din[9:8])
                    2'b00: m_wr = int'(din[7:0]) % DEPTH;
                    2'b01: begin
                        m_mem[m_wr] = din[7:0];
                        m_known[m_wr] = 1;
                        if (AUTOINC) m_wr = (m_wr + 1) % DEPTH;
                    end
                    2'b10: begin
                        m_rd = int'(din[7:0]) % DEPTH;
                        m_vld = 1;
                    end
                    default: begin
                        m_dout = m_mem[m_rd];
                        m_dknown = m_known[m_rd];
                        m_left = HOLD;
                        m_seq = !m_vld;
                        if (AUTOINC) m_rd = (m_rd + 1) % DEPTH;
                        else m_vld = 0;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if (tx_valid !== (m_left > 0)) begin
                errors++;
                $display("FAIL model_tx_valid t=%0t got %b expected %b", $time, tx_valid, (m_left > 0));
            end
            checks++;
            if (seq_err !== m_seq) begin
                errors++;
                $display("FAIL model_seq_err t=%0t got %b expected %b", $time, seq_err, m_seq);
            end
            if (m_dknown) begin
                checks++;
                if (dout !== m_dout) begin
                    errors++;
                    $display("FAIL model_dout t=%0t got %h expected %h", $time, dout, m_dout);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] p);
        din = {c, p};
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        din = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic count_tx(output int n);
        n = 0;
        while (tx_valid === 1'b1 && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2 rst_n = 1'b0;
        #1 armed = 1'b1;
        chk("reset_dout", dout, 8'h00);
        chk("reset_tx_valid", tx_valid, 1'b0);
        chk("reset_seq_err", seq_err, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Seed mem[0] and mem[0x12]
        send(2'b00, 8'h00);
        send(2'b01, 8'h3C);
        send(2'b00, 8'h12);
        send(2'b01, 8'hA5);
        send(2'b10, 8'h12);
        send(2'b11, 8'h00);
        chk("rd_a5_dout", dout, 8'hA5);
        chk("rd_a5_tx_valid", tx_valid, 1'b1);
        chk("rd_a5_seq_err", seq_err, 1'b0);
        count_tx(n);
        chk("rd_a5_tx_len", n, HOLD);
        chk("idle_keeps_dout", dout, 8'hA5);

        // Read straight after reset: no valid read address
        pulse_reset();
        chk("post_reset_dout", dout, 8'h00);
        send(2'b11, 8'h00);
        chk("noaddr_dout", dout, 8'h3C);
        chk("noaddr_seq_err", seq_err, 1'b1);
        count_tx(n);
        chk("noaddr_tx_len", n, HOLD);

        // Address/data writes during TX
        send(2'b10, 8'h12);
        send(2'b11, 8'h00);
        send(2'b00, 8'h40);
        send(2'b01, 8'h77);
        chk("tx_wr_tx_valid", tx_valid, 1'b1);
        chk("tx_wr_dout", dout, 8'hA5);
        idle(12);
        chk("tx_wr_idle_tx_valid", tx_valid, 1'b0);
        send(2'b10, 8'h40);
        send(2'b11, 8'h00);
        chk("rd_77_dout", dout, 8'h77);

        // Reload during TX restarts the hold window
        idle(3);
        send(2'b10, 8'h12);
        send(2'b11, 8'h00);
        chk("reload_dout", dout, 8'hA5);
        count_tx(n);
        chk("reload_tx_len", n, HOLD);

        // Reset in the 4th TX cycle
        send(2'b10, 8'h12);
        send(2'b11, 8'h00);
        idle(3);
        chk("pre_rst_tx_valid", tx_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_valid", tx_valid, 1'b0);
        chk("mid_rst_dout", dout, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        send(2'b10, 8'h12);
        send(2'b11, 8'h00);
        chk("mem_survives_reset", dout, 8'hA5);
        idle(2);

        // Second read without a fresh read address
        send(2'b11, 8'h00);
        chk("second_read_seq_err", seq_err, AUTOINC ? 1'b0 : 1'b1);
        count_tx(n);

`ifdef SPI_RAM_AUTOINC_EN
        send(2'b00, 8'hFF);
        send(2'b01, 8'h11);
        send(2'b01, 8'h22);
        send(2'b10, 8'hFF);
        send(2'b11, 8'h00);
        chk("autoinc_rd0", dout, 8'h11);
        send(2'b11, 8'h00);
        chk("autoinc_rd1_wrap", dout, 8'h22);
        chk("autoinc_seq_err", seq_err, 1'b0);
        count_tx(n);
`endif

        idle(2);
        armed = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
